switch_press_repeat: RTL and testbench
======================================

# switch_press_repeat

Upstream input stage for the counter and seven-segment path. It takes one raw push-button input, synchronises and debounces it, and emits single-cycle press and release pulses. While the button is held it also emits auto-repeat pulses, so a held button steps the downstream digit counter at a fixed rate. The downstream counter consumes `o_Press` or `o_Repeat` directly and needs no edge detection of its own.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: cycles the synchronised input must stay stable before the debounced level changes (10 ms at 25 MHz); must be ≥2.
- `HOLD_LIMIT`, default 12500000: cycles from press to the first repeat pulse (500 ms); must be ≥2.
- `REPEAT_LIMIT`, default 2500000: cycles between later repeat pulses (100 ms); must be ≥2.
- `CLK`: input, 1 bit. Single clock; all logic is on its rising edge.
- `RST_N`: input, 1 bit. Reset is synchronous and active-low.
- `Switch`: input, 1 bit. Raw, asynchronous button level; 1 = pressed.
- `o_Switch`: output, 1 bit. Debounced level.
- `o_Press`: output, 1 bit. One-cycle pulse on debounced 0→1.
- `o_Release`: output, 1 bit. One-cycle pulse on debounced 1→0.
- `o_Repeat`: output, 1 bit. One-cycle auto-repeat pulse while held.
- `o_Held`: output, 1 bit. High once the hold threshold has elapsed; stays high until release.

## Operation
- **Synchroniser:** two flops. Their output is `sync`.
- **Debounce filter:**
  - `cnt` clears whenever `sync == stable`.
  - Otherwise `cnt` increments each cycle.
  - When `cnt == DEBOUNCE_LIMIT-1` and `sync` still differs from `stable`: `stable <= sync` and `cnt <= 0`.
  - Any bounce back to `stable` restarts the count from zero.
- **Outputs:** `o_Switch = stable`. `o_Press` and `o_Release` are registered and are high in exactly the first cycle `o_Switch` shows the new level.
- **Hold state machine** (states IDLE, WAIT_HOLD, REPEAT; one shared hold counter `hcnt`):
  - IDLE: on the press update → WAIT_HOLD, `hcnt <= 0`.
  - WAIT_HOLD: `hcnt` increments. At `hcnt == HOLD_LIMIT-1`: `o_Repeat` pulses, `o_Held <= 1`, `hcnt <= 0`, → REPEAT.
  - REPEAT: `hcnt` increments. At `hcnt == REPEAT_LIMIT-1`: `o_Repeat` pulses, `hcnt <= 0`.
  - Release update, from any state: → IDLE, `hcnt <= 0`, `o_Held <= 0`.
- **Simultaneous events:** if a release update coincides with a repeat terminal count, release wins and `o_Repeat` stays 0. `o_Press`, `o_Release` and `o_Repeat` are never high in the same cycle.
- **Widths:** `cnt` is `$clog2(DEBOUNCE_LIMIT)` bits. `hcnt` is `$clog2(max(HOLD_LIMIT, REPEAT_LIMIT))` bits. Neither counter ever wraps; both clear explicitly at their terminal value.

## Timing
- **Reset values:** while `RST_N=0` at a clock edge, every flop clears: synchronisers, `stable`, `cnt`, `hcnt`, state = IDLE. All outputs are 0.
- **Button held through reset:** a button held during reset is seen as a fresh press after the debounce interval. `o_Press` fires.
- **Reset mid-hold:** reset during a hold aborts it. No `o_Release` is generated.
- **Press latency:** `Switch` rises and then stays stable. `o_Switch` and `o_Press` go high exactly 2 + DEBOUNCE_LIMIT edges later (2 synchroniser + DEBOUNCE_LIMIT filter).
- **Release latency:** same as press, with `o_Release`.
- **First repeat:** `o_Repeat` and `o_Held` rise HOLD_LIMIT cycles after the `o_Press` cycle.
- **Later repeats:** one `o_Repeat` every REPEAT_LIMIT cycles after that.
- **Glitch rejection:** a pulse on `Switch` shorter than DEBOUNCE_LIMIT cycles, measured at `sync`, produces no output activity.

## Structure
- **Shared package** (`input_pkg`) holds:
  - FSM state encoding: IDLE=2'd0, WAIT_HOLD=2'd1, REPEAT=2'd2. Code 2'd3 is unused and recovers to IDLE.
  - Default timing constants for the 25 MHz board clock.
- **Sub-module** `switch_filter`: synchroniser, debounce counter and edge pulses. Outputs `stable`, `rise`, `fall`.
- **Top:** instantiates `switch_filter` and holds the hold state machine.

## Test plan
All scenarios use DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=3.
- **Reset:** hold `RST_N=0` for 3 cycles with `Switch=1` → all outputs 0 during reset. After release, `o_Press` fires exactly 6 cycles later.
- **Clean press/release:** `Switch` 0→1 at cycle 0, held for 8 cycles, then 0 → `o_Press` high only at cycle 6, `o_Switch` high cycles 6–13, `o_Release` high only at cycle 14, `o_Repeat` never high.
- **Bounce:** `Switch` toggles 1,0,1,0 on alternating cycles, then stays 1 → no pulses during the toggling. `o_Press` fires 6 cycles after the final rise.
- **Auto-repeat:** `o_Press` at cycle P, button held → `o_Repeat` at P+10, P+13, P+16. `o_Held` is high from P+10.
- **Release collides with repeat:** time the release so the debounced fall lands on a repeat terminal cycle → `o_Release`=1, `o_Repeat`=0 in that cycle. `o_Held` falls and the state returns to IDLE.
- **Reset mid-hold:** assert `RST_N=0` for 1 cycle in REPEAT with `Switch` still 1 → `o_Held` is 0 the next cycle and no `o_Release`. `o_Press` fires again 6 cycles after reset is deasserted.

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the push-button input stage: hold FSM encoding and
// default timing constants for the 25 MHz board clock.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } hold_state_t;

  localparam int unsigned DEF_DEBOUNCE_LIMIT = 250000;    // 10 ms
  localparam int unsigned DEF_HOLD_LIMIT     = 12500000;  // 500 ms
  localparam int unsigned DEF_REPEAT_LIMIT   = 2500000;   // 100 ms

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_filter.sv
// Two-flop synchroniser, debounce counter and registered edge pulses.
// press_evt/release_evt are the combinational update strobes (the edge on which stable changes).
module switch_filter
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Switch,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic press_evt,
  output logic release_evt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          update;

  assign update      = (sync != stable) && (cnt == CNT_LAST);
  assign press_evt   = update && sync;
  assign release_evt = update && !sync;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta <= Switch;
      sync <= meta;
      rise <= press_evt;
      fall <= release_evt;
      if (sync == stable) begin
        cnt <= '0;
      end else if (update) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_press_repeat.sv
// Debounced push-button with press/release pulses and auto-repeat while held.
// The hold FSM advances on the filter's update strobe so its outputs line up with o_Press.
module switch_press_repeat
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int unsigned HOLD_LIMIT     = DEF_HOLD_LIMIT,
  parameter int unsigned REPEAT_LIMIT   = DEF_REPEAT_LIMIT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat,
  output logic o_Held
);

  localparam int unsigned HW = $clog2(max_u(HOLD_LIMIT, REPEAT_LIMIT));
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_LIMIT - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_LIMIT - 1);

  logic stable, rise, fall, press_evt, release_evt;

  switch_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_filter (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Switch     (Switch),
    .stable     (stable),
    .rise       (rise),
    .fall       (fall),
    .press_evt  (press_evt),
    .release_evt(release_evt)
  );

  assign o_Switch  = stable;
  assign o_Press   = rise;
  assign o_Release = fall;

  hold_state_t   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          repeat_d, held_d;
  logic          hold_term, repeat_term;

  assign hold_term   = (hcnt_q == HOLD_LAST);
  assign repeat_term = (hcnt_q == REPEAT_LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      o_Repeat <= 1'b0;
      o_Held   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      o_Repeat <= repeat_d;
      o_Held   <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (press_evt) state_d = WAIT_HOLD;
      WAIT_HOLD: if (hold_term) state_d = REPEAT;
      REPEAT:    state_d = REPEAT;
      default:   state_d = IDLE;
    endcase
    if (release_evt) state_d = IDLE;
  end

  // Release overrides any coincident terminal count, suppressing that repeat.
  always_comb begin
    hcnt_d   = hcnt_q;
    repeat_d = 1'b0;
    held_d   = o_Held;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        held_d = 1'b0;
      end
      WAIT_HOLD: begin
        if (hold_term) begin
          hcnt_d   = '0;
          repeat_d = 1'b1;
          held_d   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      REPEAT: begin
        if (repeat_term) begin
          hcnt_d   = '0;
          repeat_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        hcnt_d = '0;
        held_d = 1'b0;
      end
    endcase
    if (release_evt) begin
      hcnt_d   = '0;
      repeat_d = 1'b0;
      held_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_press_repeat.sv
// Scoreboard bench for switch_press_repeat with DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=3.
module tb_switch_press_repeat;

  logic CLK = 1'b0;
  logic RST_N;
  logic Switch;
  logic o_Switch, o_Press, o_Release, o_Repeat, o_Held;

  switch_press_repeat #(
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (10),
    .REPEAT_LIMIT  (3)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Switch   (Switch),
    .o_Switch (o_Switch),
    .o_Press  (o_Press),
    .o_Release(o_Release),
    .o_Repeat (o_Repeat),
    .o_Held   (o_Held)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // v = {press, release, repeat, held}
  typedef struct {
    int         cyc;
    logic [3:0] v;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void expect_ev(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endfunction

  function automatic logic [4:0] outs();
    return {o_Switch, o_Press, o_Release, o_Repeat, o_Held};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got={sw,pr,rel,rep,held}=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  // Monitor: every pulse on a pulse output must match the next expected event.
  always @(negedge CLK) begin
    ev_t        e;
    logic [3:0] act;
    act = {o_Press, o_Release, o_Repeat, o_Held};
    if (o_Press || o_Release || o_Repeat) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b want=no pulse", cyc, act);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.v !== act) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d v=%b want cyc=%0d v=%b", cyc, act, e.cyc, e.v);
        end
      end
    end
  end

  initial begin
    int p;
    int c;

    // Reset with button held, then continue into auto-repeat and a colliding release
    RST_N  = 1'b0;
    Switch = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("reset_outputs", outs(), 5'b00000);
    end
    RST_N = 1'b1;
    p = cyc + 6;
    expect_ev(p,      4'b1000);
    expect_ev(p + 10, 4'b0011);
    expect_ev(p + 13, 4'b0011);
    expect_ev(p + 16, 4'b0011);
    expect_ev(p + 19, 4'b0100);
    wait_until(p - 1);
    chk("pre_press", outs(), 5'b00000);
    wait_until(p + 9);
    chk("held_before_threshold", outs(), 5'b10000);
    wait_until(p + 11);
    chk("held_after_threshold", outs(), 5'b10001);
    wait_until(p + 13);
    Switch = 1'b0;
    wait_until(p + 19);
    chk("release_wins_collision", outs(), 5'b00100);
    wait_until(p + 25);
    chk("idle_after_collision", outs(), 5'b00000);

    // Clean press/release
    c = cyc;
    Switch = 1'b1;
    expect_ev(c + 6,  4'b1000);
    expect_ev(c + 14, 4'b0100);
    wait_until(c + 5);
    chk("clean_before_press", outs(), 5'b00000);
    wait_until(c + 6);
    chk("clean_press", outs(), 5'b11000);
    wait_until(c + 8);
    Switch = 1'b0;
    wait_until(c + 13);
    chk("clean_last_high", outs(), 5'b10000);
    wait_until(c + 14);
    chk("clean_release", outs(), 5'b00100);
    wait_until(c + 20);
    chk("clean_idle", outs(), 5'b00000);

    // Bounce: 1,0,1,0 then steady 1
    c = cyc;
    Switch = 1'b1;
    wait_until(c + 1); Switch = 1'b0;
    wait_until(c + 2); Switch = 1'b1;
    wait_until(c + 3); Switch = 1'b0;
    wait_until(c + 4); Switch = 1'b1;
    expect_ev(c + 10, 4'b1000);
    expect_ev(c + 18, 4'b0100);
    wait_until(c + 9);
    chk("bounce_rejected", outs(), 5'b00000);
    wait_until(c + 10);
    chk("bounce_press", outs(), 5'b11000);
    wait_until(c + 12);
    Switch = 1'b0;
    wait_until(c + 24);
    chk("bounce_idle", outs(), 5'b00000);

    // Reset mid-hold while in REPEAT
    c = cyc;
    Switch = 1'b1;
    expect_ev(c + 6,  4'b1000);
    expect_ev(c + 16, 4'b0011);
    wait_until(c + 17);
    chk("in_repeat", outs(), 5'b10001);
    RST_N = 1'b0;
    wait_until(c + 18);
    RST_N = 1'b1;
    chk("held_cleared_by_reset", outs(), 5'b00000);
    expect_ev(c + 24, 4'b1000);
    wait_until(c + 23);
    chk("no_release_after_reset", outs(), 5'b00000);
    wait_until(c + 26);
    Switch = 1'b0;
    expect_ev(c + 32, 4'b0100);
    wait_until(c + 40);
    chk("final_idle", outs(), 5'b00000);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d outstanding want 0 (next cyc=%0d v=%b)",
               q.size(), q[0].cyc, q[0].v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
